// File: rtl/io_bus_pkg.sv
// io_bus_pkg: register map, status bit positions and FSM state encoding
// shared by the switch/LED peripheral bus initiator.
package io_bus_pkg;
   localparam logic [1:0] ADDR_STATUS = 2'b00;
   localparam logic [1:0] ADDR_LED    = 2'b01;
   localparam logic [1:0] ADDR_SW_LO  = 2'b10;
   localparam logic [1:0] ADDR_SW_HI  = 2'b11;
   localparam int ST_IN_RDY  = 1;
   localparam int ST_OUT_ACK = 0;
   typedef enum logic [3:0] {
      IDLE, RD_ST_IN, CAP_ST_IN, GAP_IN, RD_HI, CAP_HI, RD_LO, CAP_LO,
      WR_LED, RD_ST_OUT, CAP_ST_OUT, GAP_OUT
   } state_t;
endpackage

// File: rtl/io_poll_master.sv
// io_poll_master: polls the switch/LED peripheral, adds both switch bytes,
// writes the sum to the LED register and waits for the display acknowledge.
module io_poll_master
   import io_bus_pkg::*;
#(
   parameter int POLL_GAP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        pRead,
   output logic        pWrite,
   output logic [1:0]  addr,
   output logic [31:0] pWriteData,
   input  logic [31:0] pReadData,
   output logic        busy,
   output logic [11:0] result,
   output logic [15:0] rounds
);
   localparam int GW = $clog2(POLL_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   state_t state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0] hi_q, hi_d;
   logic [11:0] result_q, result_d;
   logic [15:0] rounds_q, rounds_d;
   logic pRead_q, pRead_d, pWrite_q, pWrite_d, busy_q, busy_d;
   logic [1:0] addr_q, addr_d;
   logic [31:0] pWriteData_q, pWriteData_d;
   logic gap_done;
   logic unused_rd;

   assign unused_rd = ^pReadData[31:8];
   assign gap_done = gap_q == GAP_LAST;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         gap_q        <= '0;
         hi_q         <= '0;
         result_q     <= '0;
         rounds_q     <= '0;
         pRead_q      <= 1'b0;
         pWrite_q     <= 1'b0;
         busy_q       <= 1'b0;
         addr_q       <= ADDR_STATUS;
         pWriteData_q <= '0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         hi_q         <= hi_d;
         result_q     <= result_d;
         rounds_q     <= rounds_d;
         pRead_q      <= pRead_d;
         pWrite_q     <= pWrite_d;
         busy_q       <= busy_d;
         addr_q       <= addr_d;
         pWriteData_q <= pWriteData_d;
      end
   end

   // Outputs are derived from the next state so each strobe is registered
   // and coincides exactly with its RD/WR state.
   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      result_d = result_q;
      rounds_d = rounds_q;
      case (state_q)
         IDLE:       state_d = enable ? RD_ST_IN : IDLE;
         RD_ST_IN:   state_d = CAP_ST_IN;
         CAP_ST_IN:  state_d = pReadData[ST_IN_RDY] ? RD_HI : GAP_IN;
         GAP_IN:     state_d = !enable ? IDLE : gap_done ? RD_ST_IN : GAP_IN;
         RD_HI:      state_d = CAP_HI;
         CAP_HI: begin
            hi_d    = pReadData[7:0];
            state_d = RD_LO;
         end
         RD_LO:      state_d = CAP_LO;
         CAP_LO:     state_d = WR_LED;
         WR_LED: begin
            result_d = pWriteData_q[11:0];
            state_d  = RD_ST_OUT;
         end
         RD_ST_OUT:  state_d = CAP_ST_OUT;
         CAP_ST_OUT: begin
            rounds_d = pReadData[ST_OUT_ACK] ? rounds_q + 16'd1 : rounds_q;
            state_d  = !pReadData[ST_OUT_ACK] ? GAP_OUT : enable ? RD_ST_IN : IDLE;
         end
         GAP_OUT:    state_d = gap_done ? RD_ST_OUT : GAP_OUT;
         default:    state_d = IDLE;
      endcase
      gap_d = ((state_q == GAP_IN || state_q == GAP_OUT) && state_d == state_q) ? gap_q + 1'b1 : '0;
      pRead_d = state_d inside {RD_ST_IN, RD_HI, RD_LO, RD_ST_OUT};
      pWrite_d = state_d == WR_LED;
      busy_d = state_d != IDLE;
      addr_d = (state_d == RD_HI) ? ADDR_SW_HI : (state_d == RD_LO) ? ADDR_SW_LO :
               (state_d == WR_LED) ? ADDR_LED : ADDR_STATUS;
      // Low byte is summed straight off the bus as CAP_LO hands over to WR_LED.
      pWriteData_d = (state_d == WR_LED) ? {23'b0, {1'b0, hi_q} + {1'b0, pReadData[7:0]}} : '0;
   end

   assign pRead      = pRead_q;
   assign pWrite     = pWrite_q;
   assign addr       = addr_q;
   assign pWriteData = pWriteData_q;
   assign busy       = busy_q;
   assign result     = result_q;
   assign rounds     = rounds_q;
endmodule

// File: tb/tb_io_poll_master.sv
// tb_io_poll_master: drives io_poll_master against a small peripheral model;
// expected LED writes are queued by the stimulus and checked by a monitor.
module tb_io_poll_master;
   logic clk, reset, enable;
   logic pRead, pWrite, busy;
   logic [1:0] addr;
   logic [31:0] pWriteData, pReadData;
   logic [11:0] result;
   logic [15:0] rounds;

   logic [15:0] sw;
   logic set_rdy, set_ack, rdy_q, ack_q;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic res_pend = 1'b0;
   logic [11:0] res_exp;

   io_poll_master #(.POLL_GAP(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pRead(pRead), .pWrite(pWrite),
      .addr(addr), .pWriteData(pWriteData), .pReadData(pReadData), .busy(busy),
      .result(result), .rounds(rounds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral: registered reads with junk in the upper bits, sticky ready
   // cleared by the low-byte read, acknowledge cleared by the LED write.
   always @(posedge clk) begin
      if (reset) begin
         pReadData <= '0;
         rdy_q <= 1'b0;
         ack_q <= 1'b0;
      end else begin
         if (pRead)
            pReadData <= (addr == 2'b00) ? {30'h2AAAAAA8, rdy_q, ack_q} :
                         (addr == 2'b11) ? {24'hA5A5A5, sw[15:8]} :
                         (addr == 2'b10) ? {24'h5A5A5A, sw[7:0]} : 32'hFFFF_FFFF;
         rdy_q <= set_rdy ? 1'b1 : (pRead && addr == 2'b10) ? 1'b0 : rdy_q;
         ack_q <= pWrite ? 1'b0 : set_ack ? 1'b1 : ack_q;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (res_pend) begin
         check("result_after_write", {20'b0, result}, {20'b0, res_exp});
         res_pend = 1'b0;
      end
      if (pRead && pWrite) check("strobe_overlap", 32'd1, 32'd0);
      if (pWrite) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", pWriteData, 32'hDEAD_BEEF);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("write_data", pWriteData, e);
            check("write_addr", {30'b0, addr}, 32'd1);
            res_exp = e[11:0];
            res_pend = 1'b1;
         end
      end
   end

   task automatic pulse_rdy();
      set_rdy = 1'b1;
      @(negedge clk);
      set_rdy = 1'b0;
   endtask

   task automatic pulse_ack();
      set_ack = 1'b1;
      @(negedge clk);
      set_ack = 1'b0;
   endtask

   task automatic wait_pread(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pRead && n < 50);
   endtask

   task automatic do_round(input logic [15:0] s, input logic [11:0] e, input logic drop_en);
      int n;
      logic [15:0] r0;
      sw = s;
      exp_q.push_back({20'b0, e});
      r0 = rounds;
      pulse_rdy();
      n = 0;
      while (!pWrite && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("write_seen", {31'b0, pWrite}, 32'd1);
      if (drop_en) enable = 1'b0;
      repeat (20) @(negedge clk);
      check("rounds_hold_no_ack", {16'b0, rounds}, {16'b0, r0});
      if (drop_en) check("busy_until_ack", {31'b0, busy}, 32'd1);
      pulse_ack();
      n = 0;
      while (rounds == r0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("rounds_incr", {16'b0, rounds}, {16'b0, r0 + 16'd1});
      check("result_hold", {20'b0, result}, {20'b0, e});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; enable = 1'b1; sw = '0; set_rdy = 1'b0; set_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pRead", {31'b0, pRead}, 32'd0);
      check("rst_pWrite", {31'b0, pWrite}, 32'd0);
      check("rst_addr", {30'b0, addr}, 32'd0);
      check("rst_wdata", pWriteData, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_result", {20'b0, result}, 32'd0);
      check("rst_rounds", {16'b0, rounds}, 32'd0);
      reset = 1'b0;
      wait_pread(n);
      check("first_poll_delay", n, 1);
      check("poll_addr", {30'b0, addr}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         wait_pread(n);
         check("poll_period", n, 6);
         check("poll_addr", {30'b0, addr}, 32'd0);
      end
      do_round(16'hFF01, 12'h100, 1'b0);
      do_round(16'h0000, 12'h000, 1'b0);
      do_round(16'hFFFF, 12'h1FE, 1'b0);
      wait_pread(n);
      check("poll_before_gap", {31'b0, pRead}, 32'd1);
      repeat (2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("gap_in_abort_busy", {31'b0, busy}, 32'd0);
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (pRead) n++;
      end
      check("idle_no_reads", n, 0);
      enable = 1'b1;
      do_round(16'h0302, 12'h005, 1'b1);
      check("gap_out_idle", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("gap_out_idle_hold", {31'b0, busy}, 32'd0);
      enable = 1'b1;
      sw = 16'h1111;
      pulse_rdy();
      n = 0;
      while (!(pRead && addr == 2'b10) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("rd_lo_seen", {30'b0, addr}, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_pRead", {31'b0, pRead}, 32'd0);
      check("mid_rst_pWrite", {31'b0, pWrite}, 32'd0);
      check("mid_rst_result", {20'b0, result}, 32'd0);
      check("mid_rst_rounds", {16'b0, rounds}, 32'd0);
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_rst_stays_idle", {31'b0, busy}, 32'd0);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_poll_master.md
# io_poll_master

Bus initiator that drives the memory-mapped switch/LED IO peripheral in place of software. It polls the peripheral status register and, when input is ready, reads both switch bytes and adds them. It writes the 12-bit sum to the LED register, then waits for the display acknowledge before starting the next round. It sits on the same pRead/pWrite/addr bus the CPU data port would otherwise drive, so the peripheral can be exercised in hardware-only builds.

## Interface
- POLL_GAP, 4: idle cycles inserted after a poll that finds its status bit clear (≥1).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  run request; sampled only in IDLE and gap states.
- pRead  out  1  read strobe to peripheral.
- pWrite  out  1  write strobe to peripheral.
- addr  out  2  register select: 00 status, 01 LED, 10 switch low byte, 11 switch high byte.
- pWriteData  out  32  write data; only bits 11:0 are meaningful.
- pReadData  in  32  peripheral read data; registered by the peripheral, valid the cycle after pRead.
- busy  out  1  high whenever state ≠ IDLE.
- result  out  12  last sum written to LED.
- rounds  out  16  count of completed rounds; wraps FFFF→0000.

## Operation
- Status bits: bit1 = input ready (sticky in peripheral), bit0 = display acknowledged (cleared by LED write).
- States: IDLE, RD_ST_IN, CAP_ST_IN, GAP_IN, RD_HI, CAP_HI, RD_LO, CAP_LO, WR_LED, RD_ST_OUT, CAP_ST_OUT, GAP_OUT.
- IDLE: enable=1 → RD_ST_IN.
- RD_x states: pRead=1, addr per register, for exactly that one cycle. Next CAP_x cycle: pRead=0, pReadData captured at the end of the cycle.
- CAP_ST_IN: bit1=1 → RD_HI; else → GAP_IN.
- GAP_IN: count POLL_GAP cycles. enable=0 → IDLE; otherwise → RD_ST_IN.
- RD_HI/CAP_HI: addr=11, capture hi=pReadData[7:0]. RD_LO/CAP_LO: addr=10, capture lo=pReadData[7:0].
- WR_LED: pWrite=1, addr=01, pWriteData={20'b0, sum}, where sum={3'b0, hi+lo} with the 9-bit carry kept. result updates at the end of this cycle.
- CAP_ST_OUT: bit0=1 → rounds+1, then RD_ST_IN if enable=1, else IDLE. bit0=0 → GAP_OUT.
- GAP_OUT: POLL_GAP cycles, then → RD_ST_OUT. enable=0 here does not abort: the round must finish.
- pRead and pWrite are never high together. addr=00 and pWriteData=0 in all non-RD/WR states.
- Upper bits of pReadData are ignored.

## Timing
- All outputs registered. Reset values: pRead=0, pWrite=0, addr=00, pWriteData=0, busy=0, result=0, rounds=0, state=IDLE, gap counter=0.
- Minimum round with both status bits already set: 9 cycles from RD_ST_IN to rounds increment.
- First poll is immediate; gaps follow only failed polls.
- WR_LED is followed directly by RD_ST_OUT. The peripheral clears bit0 on the write edge, so a stale acknowledge is never seen.
- reset mid-transaction: return to IDLE next edge; strobes drop that edge; no partial write is issued.
- enable toggled inside an RD/CAP/WR state is ignored until the next gap or IDLE.

## Structure
- Package io_bus_pkg: addr constants ADDR_STATUS, ADDR_LED, ADDR_SW_LO, ADDR_SW_HI; status bit indices ST_IN_RDY=1, ST_OUT_ACK=0; state enum type.
- Single module. The gap counter is inline (width $clog2(POLL_GAP+1)); no sub-module.

## Test plan
- Reset held 3 cycles with enable=1 → all outputs 0, state IDLE, no strobes.
- enable=1, status=00 → status reads recur every 2+POLL_GAP cycles, addr=00, pWrite never high.
- Status bit1=1, switch=16'hFF01 → reads at addr 11 then 10, then write of pWriteData=32'h100 at addr 01; result=12'h100.
- After the write, bit0 stays 0 for 20 cycles, then is set → rounds 0→1 on the first poll seeing bit0=1.
- switch=16'h0000 and 16'hFFFF → sums 12'h000 and 12'h1FE.
- reset asserted in RD_LO → next edge IDLE, no pWrite. Drop enable in GAP_IN → IDLE; drop it in GAP_OUT → round completes, then IDLE.
